mux_nch_stream: RTL and testbench

//  N-channel, W-bit stream multiplexer with a registered output stage and valid/ready handshake.

---
 rtl/mux_nch_stream.sv | 127 ++++++++++++
 tb/tb_mux_nch_stream.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nch_stream.sv
// mux_nch_stream: N-channel, W-bit stream multiplexer with a registered
// output stage. Fixed-select or round-robin channel choice, valid/ready on
// both sides. One word per cycle when the consumer keeps out_ready high.

// Per-channel ready generation: a lane is ready only when the output
// register can load and the grant points at this lane.
module mux_nch_lane #(
    parameter int CW  = 2,
    parameter int IDX = 0
) (
    input  logic          en,
    input  logic [CW-1:0] gnt,
    output logic          rdy
);
    assign rdy = en & (gnt == CW'(IDX));
endmodule

module mux_nch_stream #(
    parameter  int W  = 4,
    parameter  int N  = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [CW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_ch,
    input  logic           out_ready
);

    // Registered output word: payload plus the channel it came from.
    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] ch;
    } out_word_t;

    out_word_t     out_q;
    logic [CW-1:0] rr_ptr;

    logic          load;
    logic          fx_valid;
    logic          rr_found;
    logic [CW-1:0] rr_gnt;
    logic          gnt_valid;
    logic [CW-1:0] gnt;
    logic          lane_en;
    logic [W-1:0]  gnt_data;

    // The register may take a new word when empty or when it drains this cycle.
    assign load = ~out_valid | out_ready;

    // Fixed mode: honour sel only when it names a real, valid channel.
    always_comb begin
        fx_valid = 1'b0;
        if (int'(sel) < N)
            fx_valid = in_valid[sel];
    end

    // Round-robin scan starting just after the last granted channel, wrapping
    // at N, so rr_ptr = N-1 starts the search at channel 0.
    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_gnt   = '0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_gnt   = CW'(idx);
            end
        end
    end

    assign gnt_valid = mode ? rr_found : fx_valid;
    assign gnt       = mode ? rr_gnt   : sel;

    // Ready is forced low while reset is held so no producer sees a handshake.
    assign lane_en = rst_n & load & gnt_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            mux_nch_lane #(.CW(CW), .IDX(gi)) u_lane (
                .en  (lane_en),
                .gnt (gnt),
                .rdy (in_ready[gi])
            );
        end
    endgenerate

    // Data steering for the granted channel (only used when gnt is in range).
    always_comb begin
        gnt_data = '0;
        if (int'(gnt) < N)
            gnt_data = in_data[int'(gnt)*W +: W];
    end

    // Output register and round-robin pointer. A held word is never touched
    // under backpressure; with no grant the valid drops but payload holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            rr_ptr    <= CW'(N - 1);
        end else if (load) begin
            if (gnt_valid) begin
                out_valid  <= 1'b1;
                out_q.data <= gnt_data;
                out_q.ch   <= gnt;
                if (mode)
                    rr_ptr <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_data = out_q.data;
    assign out_ch   = out_q.ch;

endmodule

// File: tb/tb_mux_nch_stream.sv
// tb_mux_nch_stream: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_mux_nch_stream;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [CW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;
    logic           out_ready;

    mux_nch_stream #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model state: what the output register must hold.
    bit       m_valid;
    int       m_data;
    int       m_ch;
    int       m_ptr;

    // Literal expectations from the directed scenarios.
    bit       lit_en;
    logic [N-1:0]  lit_rdy;
    logic          lit_v;
    logic [W-1:0]  lit_d;
    logic [CW-1:0] lit_ch;

    int n_pass  = 0;
    int n_total = 0;

    // Which channel the rules grant right now, or -1 for none.
    function automatic int model_gnt();
        if (!mode)
            return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++)
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // Model advances on each clock edge, cleared immediately by reset.
    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = N - 1;
        end else if (!m_valid || out_ready) begin
            g = model_gnt();
            if (g >= 0) begin
                m_valid = 1;
                m_data  = int'(in_data[g*W +: W]);
                m_ch    = g;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // Single compare process, sampling mid-cycle on the falling edge.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        g = model_gnt();
        exp_rdy = '0;
        if (rst_n && (!m_valid || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ch",    32'(out_ch),    32'(m_ch));
        if (lit_en) begin
            chk("lit_in_ready",  32'(in_ready),  32'(lit_rdy));
            chk("lit_out_valid", 32'(out_valid), 32'(lit_v));
            chk("lit_out_data",  32'(out_data),  32'(lit_d));
            chk("lit_out_ch",    32'(out_ch),    32'(lit_ch));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input logic [N-1:0] r, input logic v,
                              input logic [W-1:0] d, input logic [CW-1:0] c);
        lit_en = 1; lit_rdy = r; lit_v = v; lit_d = d; lit_ch = c;
    endtask

    initial begin
        lit_en = 0; lit_rdy = '0; lit_v = 0; lit_d = '0; lit_ch = '0;
        // Reset with every input active.
        rst_n = 0; mode = 1; sel = 0; in_valid = 4'b1111;
        in_data = {4'hD, 4'hC, 4'hB, 4'hA}; out_ready = 1;
        expect_lit(4'b0000, 0, 4'h0, 2'd0); step();
        expect_lit(4'b0000, 0, 4'h0, 2'd0); step();

        // Round-robin from reset: 0,1,2,3,0.
        rst_n = 1;
        expect_lit(4'b0001, 0, 4'h0, 2'd0); step();
        expect_lit(4'b0010, 1, 4'hA, 2'd0); step();
        expect_lit(4'b0100, 1, 4'hB, 2'd1); step();
        expect_lit(4'b1000, 1, 4'hC, 2'd2); step();
        expect_lit(4'b0001, 1, 4'hD, 2'd3); step();

        // Backpressure with channel 0 in the register, then release.
        out_ready = 0;
        expect_lit(4'b0000, 1, 4'hA, 2'd0); step();
        expect_lit(4'b0000, 1, 4'hA, 2'd0); step();
        out_ready = 1;
        expect_lit(4'b0010, 1, 4'hA, 2'd0); step();

        // Sparse round-robin 1,3,1,3 then only channel 1.
        in_valid = 4'b1010;
        expect_lit(4'b1000, 1, 4'hB, 2'd1); step();
        expect_lit(4'b0010, 1, 4'hD, 2'd3); step();
        expect_lit(4'b1000, 1, 4'hB, 2'd1); step();
        in_valid = 4'b0010;
        expect_lit(4'b0010, 1, 4'hD, 2'd3); step();
        expect_lit(4'b0010, 1, 4'hB, 2'd1); step();

        // Fixed select on channel 2.
        mode = 0; sel = 2; in_valid = 4'b1111;
        expect_lit(4'b0100, 1, 4'hB, 2'd1); step();
        expect_lit(4'b0100, 1, 4'hC, 2'd2); step();

        // Selected channel idle: valid drops, payload holds.
        sel = 1; in_valid = 4'b1101;
        expect_lit(4'b0000, 1, 4'hC, 2'd2); step();
        expect_lit(4'b0000, 0, 4'hC, 2'd2); step();
        sel = 2; in_valid = 4'b1111;
        expect_lit(4'b0100, 0, 4'hC, 2'd2); step();

        // Reset asserted mid-cycle must clear outputs before the next edge.
        expect_lit(4'b0000, 0, 4'h0, 2'd0);
        #1 rst_n = 0;
        step();
        rst_n = 1;
        expect_lit(4'b0100, 0, 4'h0, 2'd0); step();
        lit_en = 0;

        // Randomized traffic, with occasional mid-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = 16'($urandom);
            out_ready = ($urandom % 4) != 0;
            if ($urandom % 200 == 0) begin
                #1 rst_n = 0;
                step();
                rst_n = 1;
            end else begin
                step();
            end
        end
        // Long round-robin burst with everything valid to exercise fairness.
        mode = 1; in_valid = 4'b1111; out_ready = 1;
        for (int c = 0; c < 40; c++) begin
            in_data = 16'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
